ccff_chain_loader: RTL and testbench

- Drives the configuration flip-flop chain from its head end.
- Accepts bitstream words on a valid/ready interface and serializes them LSB-first onto ccff_head.
- Produces a per-cycle shift enable for the prog_clk gate of the tile chain and counts exactly CHAIN_LEN shifts per load.
- Sits between the bitstream source (config controller) and the first tile's ccff_head; ccff_tail of the last tile returns to this block.

---
 rtl/ccff_loader_pkg.sv | 10 +
 rtl/ccff_chain_loader_serializer.sv | 35 +++
 rtl/ccff_chain_loader.sv | 90 +++++++++
 tb/tb_ccff_chain_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: state encoding and sizing helpers shared by the config-chain loader
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/ccff_chain_loader_serializer.sv
// ccff_word_serializer: one-word PISO holding the not-yet-presented bits of the current word
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              load,
  input  logic              shift,
  input  logic              flush,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              empty
);
  localparam int RW = cnt_w(WORD_W);
  logic [WORD_W-1:0] sr;
  logic [RW-1:0]     rem;
  assign bit_out = sr[0];
  assign empty   = rem == '0;
  // bit 0 of a loaded word goes straight to the head register, so only the rest is kept
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      sr  <= '0;
      rem <= '0;
    end else if (flush) begin
      rem <= '0;
    end else if (load) begin
      sr  <= data >> 1;
      rem <= RW'(WORD_W - 1);
    end else if (shift) begin
      sr  <= sr >> 1;
      rem <= rem - RW'(1);
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes bitstream words LSB-first into the config chain head
// Optional readback verify pass, mismatch_cnt port and error flag enabled by CCFF_READBACK_EN.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef CCFF_READBACK_EN
  ,
  output logic [cnt_w(CHAIN_LEN)-1:0] mismatch_cnt
`endif
);
  localparam int CW = cnt_w(CHAIN_LEN);
`ifdef CCFF_READBACK_EN
  localparam state_t AFTER_LOAD = VERIFY;
`else
  localparam state_t AFTER_LOAD = FINISH;
`endif
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          active, need, pass_end, present, buf_empty, buf_bit;
  assign active   = state == LOAD || state == VERIFY;
  // bits already presented (shifted plus the one on the head now) still short of the chain
  assign need     = cnt + CW'(chain_shift_en) < CW'(CHAIN_LEN);
  assign pass_end = chain_shift_en && cnt == CW'(CHAIN_LEN - 1);
  assign present  = active && need && (!buf_empty || word_valid);
  always_comb begin
    state_nxt  = state;
    busy       = active;
    done       = state == FINISH;
    word_ready = active && buf_empty && need;
    if (state == IDLE) state_nxt = start ? LOAD : IDLE;
    else if (state == FINISH) state_nxt = IDLE;
    else if (pass_end) state_nxt = state == LOAD ? AFTER_LOAD : FINISH;
  end
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ccff_head      <= 1'b0;
      chain_shift_en <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= (state == IDLE || pass_end) ? '0 : cnt + CW'(chain_shift_en);
      chain_shift_en <= present;
      if (present) ccff_head <= buf_empty ? word_data[0] : buf_bit;
    end
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .load     (word_ready && word_valid),
    .shift    (active && need && !buf_empty),
    .flush    (pass_end),
    .data     (word_data),
    .bit_out  (buf_bit),
    .empty    (buf_empty)
  );
`ifdef CCFF_READBACK_EN
  logic mis;
  assign mis = state == VERIFY && chain_shift_en && ccff_tail != ccff_head;
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (state == IDLE && start) begin
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (mis) begin
      error        <= 1'b1;
      mismatch_cnt <= mismatch_cnt + CW'(~&mismatch_cnt);
    end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader against behavioural chain models
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0;
  logic pReset_n = 1'b1;
  always #5 prog_clk = ~prog_clk;

  logic        a_start = 0, a_valid = 0, a_ready, a_head, a_sen, a_busy, a_done, a_err, a_tail;
  logic [7:0]  a_data = 0;
  logic        b_start = 0, b_valid = 0, b_ready, b_head, b_sen, b_busy, b_done, b_err, b_tail;
  logic [7:0]  b_data = 0;
`ifdef CCFF_READBACK_EN
  logic [3:0]  a_mcnt, b_mcnt;
`endif
  logic [7:0]  ch_a = 0;
  logic [11:0] ch_b = 0;
  logic        stuck = 0;
  int a_hs = 0, b_hs = 0, a_shifts = 0, a_dones = 0;
  int checks = 0, errors = 0;

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(a_start), .word_data(a_data),
    .word_valid(a_valid), .word_ready(a_ready), .ccff_head(a_head), .chain_shift_en(a_sen),
    .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .error(a_err)
`ifdef CCFF_READBACK_EN
    , .mismatch_cnt(a_mcnt)
`endif
  );
  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(b_start), .word_data(b_data),
    .word_valid(b_valid), .word_ready(b_ready), .ccff_head(b_head), .chain_shift_en(b_sen),
    .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .error(b_err)
`ifdef CCFF_READBACK_EN
    , .mismatch_cnt(b_mcnt)
`endif
  );

  // chain models: bit 0 is the tail-most flop; optional stuck-at-0 flop at position 3
  assign a_tail = ch_a[0];
  assign b_tail = ch_b[0];
  always @(posedge prog_clk) begin
    if (a_sen) ch_a <= {a_head, ch_a[7:1]} & (stuck ? 8'hF7 : 8'hFF);
    if (b_sen) ch_b <= {b_head, ch_b[11:1]};
    if (a_valid && a_ready) a_hs <= a_hs + 1;
    if (b_valid && b_ready) b_hs <= b_hs + 1;
    if (a_sen) a_shifts <= a_shifts + 1;
    if (a_done) a_dones <= a_dones + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] w, input logic mid_start, input logic with_start);
    if (with_start) begin
      a_start = 1; tick; a_start = 0;
    end
    chk("a_busy_pass", a_busy, 1);
    chk("a_ready_pass", a_ready, 1);
    a_data = w; a_valid = 1; tick; a_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("a_sen", a_sen, 1);
      chk("a_head", a_head, w[i]);
      a_start = mid_start && i == 3;
      tick;
      a_start = 0;
    end
  endtask

  task automatic finish_a();
    chk("a_done_pulse", a_done, 1);
    chk("a_sen_finish", a_sen, 0);
    tick;
    chk("a_done_low", a_done, 0);
    chk("a_busy_idle", a_busy, 0);
  endtask

  initial begin
    int h0, s0, d0;
    logic hs;
    logic [11:0] want12;
    #1 pReset_n = 0;
    #1;
    chk("rst_a", {a_ready, a_head, a_sen, a_busy, a_done, a_err}, 0);
    chk("rst_b", {b_ready, b_head, b_sen, b_busy, b_done, b_err}, 0);
    tick; tick;
    pReset_n = 1;
    tick;

    h0 = a_hs;
    a_data = 8'hFF; a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_ready", a_ready, 0);
      tick;
    end
    a_valid = 0;
    chk("idle_no_hs", a_hs - h0, 0);
    chk("idle_no_shift", a_sen, 0);

    d0 = a_dones;
    a_start = 1; tick; a_start = 0;
    a_data = 8'hFF; a_valid = 1; tick; a_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_sen", a_sen, 1);
      tick;
    end
    pReset_n = 0;
    #1;
    chk("abort_outputs", {a_ready, a_head, a_sen, a_busy, a_done, a_err}, 0);
    tick;
    chk("abort_no_done", a_dones - d0, 0);
    pReset_n = 1;
    tick;

`ifndef CCFF_READBACK_EN
    h0 = a_hs;
    load_a(8'h5A, 0, 1);
    finish_a;
    chk("reload_chain", ch_a, 8'h5A);
    chk("reload_hs", a_hs - h0, 1);

    h0 = a_hs;
    load_a(8'hA5, 0, 1);
    finish_a;
    chk("single_chain", ch_a, 8'hA5);
    chk("single_hs", a_hs - h0, 1);

    s0 = a_shifts;
    load_a(8'h3C, 1, 1);
    finish_a;
    tick;
    chk("midstart_shifts", a_shifts - s0, 8);
    chk("midstart_chain", ch_a, 8'h3C);
    chk("midstart_idle", a_busy, 0);

    h0 = b_hs;
    want12 = 12'h73C;
    b_start = 1; tick; b_start = 0;
    chk("trunc_ready", b_ready, 1);
    b_data = 8'h3C; b_valid = 1; tick;
    b_data = 8'hF7;
    for (int i = 0; i < 12; i++) begin
      chk("trunc_sen", b_sen, 1);
      chk("trunc_head", b_head, want12[i]);
      hs = b_ready;
      tick;
      if (hs) b_valid = 0;
    end
    chk("trunc_done", b_done, 1);
    chk("trunc_sen_off", b_sen, 0);
    chk("trunc_chain", ch_b, 12'h73C);
    chk("trunc_hs", b_hs - h0, 2);
    tick;

    h0 = b_hs;
    want12 = 12'h7BC;
    b_start = 1; tick; b_start = 0;
    b_data = 8'hBC; b_valid = 1; tick; b_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("stall_sen", b_sen, 1);
      chk("stall_head", b_head, want12[i]);
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      chk("stall_gap", b_sen, 0);
      chk("stall_hold", b_head, 1);
      chk("stall_ready", b_ready, 1);
      if (i == 2) begin
        b_data = 8'hF7; b_valid = 1;
      end
      tick;
    end
    b_valid = 0;
    for (int i = 8; i < 12; i++) begin
      chk("stall_sen2", b_sen, 1);
      chk("stall_head2", b_head, want12[i]);
      tick;
    end
    chk("stall_done", b_done, 1);
    chk("stall_chain", ch_b, 12'h7BC);
    chk("stall_hs", b_hs - h0, 2);
    tick;
`else
    stuck = 0;
    d0 = a_dones;
    load_a(8'hA5, 0, 1);
    chk("rb_no_done_after_load", a_dones - d0, 0);
    load_a(8'hA5, 0, 0);
    finish_a;
    chk("rb_clean_err", a_err, 0);
    chk("rb_clean_cnt", a_mcnt, 0);
    chk("rb_clean_chain", ch_a, 8'hA5);

    stuck = 1;
    load_a(8'h08, 0, 1);
    load_a(8'h08, 0, 0);
    finish_a;
    chk("rb_stuck_err", a_err, 1);
    chk("rb_stuck_cnt", a_mcnt, 1);
    tick;
    chk("rb_sticky", a_err, 1);
    stuck = 0;
    a_start = 1; tick; a_start = 0;
    chk("rb_clear_err", a_err, 0);
    chk("rb_clear_cnt", a_mcnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
